// File: rtl/goertzel_pkg.sv
// ----------------------------------------------------------------------------
// goertzel_pkg: op codes, scheduler state encoding and shared counter widths.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package goertzel_pkg;

  localparam int FRAME_CNT_W = 16;
  localparam int DROP_CNT_W  = 8;
  localparam int OP_W        = 2;
  localparam int ST_W        = 2;

  localparam logic [OP_W-1:0] OP_CLEAR = 2'd0;
  localparam logic [OP_W-1:0] OP_ITER  = 2'd1;
  localparam logic [OP_W-1:0] OP_FINAL = 2'd2;

  localparam logic [ST_W-1:0] ST_CLEAR = 2'd0;
  localparam logic [ST_W-1:0] ST_WAIT  = 2'd1;
  localparam logic [ST_W-1:0] ST_ITER  = 2'd2;
  localparam logic [ST_W-1:0] ST_FINAL = 2'd3;

endpackage

`default_nettype wire

// File: rtl/goertzel_ovr_mon.sv
// ----------------------------------------------------------------------------
// goertzel_ovr_mon: sticky overrun flag and saturating dropped-sample counter.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module goertzel_ovr_mon
  import goertzel_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  drop,
  output logic                  overrun,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun  <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (clr) begin
        overrun <= 1'b0;
      end else if (drop) begin
        overrun <= 1'b1;
      end
      if (drop && (drop_cnt != {DROP_CNT_W{1'b1}})) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/goertzel_sched.sv
// ----------------------------------------------------------------------------
// goertzel_sched: frame scheduler sequencing CLEAR/ITER/FINAL ops onto one
// shared Goertzel datapath. Define GOERTZEL_SCHED_OVERRUN_EN for the drop monitor.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module goertzel_sched
  import goertzel_pkg::*;
#(
  parameter int NUM_FREQS  = 10,
  parameter int FRAME_LEN  = 256,
  parameter int DATA_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic                         soft_clr,
  input  logic signed [DATA_WIDTH-1:0] sample_in,
  input  logic                         sample_valid,
  output logic                         sample_ready,
  output logic                         dp_valid,
  output logic [OP_W-1:0]              dp_op,
  output logic [$clog2(NUM_FREQS)-1:0] dp_bin,
  output logic signed [DATA_WIDTH-1:0] dp_sample,
  input  logic                         res_ready,
  output logic                         frame_done,
  output logic [FRAME_CNT_W-1:0]       frame_cnt,
  output logic                         overrun,
  output logic [DROP_CNT_W-1:0]        drop_cnt
);

  localparam int BIN_W = $clog2(NUM_FREQS);
  localparam int CNT_W = $clog2(FRAME_LEN);
  localparam logic [BIN_W-1:0] LAST_BIN    = BIN_W'(NUM_FREQS - 1);
  localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(FRAME_LEN - 1);

  logic [ST_W-1:0]  state, state_nxt;
  logic [BIN_W-1:0] bin, bin_nxt;
  logic [CNT_W-1:0] sample_cnt, sample_cnt_nxt;
  logic             live;
  logic             accept;
  logic             frame_end;

  // live holds every output at zero until the first clock after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_CLEAR;
      bin        <= '0;
      sample_cnt <= '0;
      live       <= 1'b0;
    end else begin
      state      <= state_nxt;
      bin        <= bin_nxt;
      sample_cnt <= sample_cnt_nxt;
      live       <= 1'b1;
    end
  end

  assign accept = live && (state == ST_WAIT) && en && sample_valid && !soft_clr;

  always_comb begin
    state_nxt      = state;
    bin_nxt        = bin;
    sample_cnt_nxt = sample_cnt;
    frame_end      = 1'b0;
    if (soft_clr) begin
      state_nxt      = ST_CLEAR;
      bin_nxt        = '0;
      sample_cnt_nxt = '0;
    end else if (live) begin
      case (state)
        ST_CLEAR: begin
          if (bin == LAST_BIN) begin
            state_nxt = ST_WAIT;
            bin_nxt   = '0;
          end else begin
            bin_nxt = bin + 1'b1;
          end
        end
        ST_WAIT: begin
          if (accept) begin
            state_nxt = ST_ITER;
            bin_nxt   = '0;
          end
        end
        ST_ITER: begin
          if (bin == LAST_BIN) begin
            bin_nxt = '0;
            if (sample_cnt == LAST_SAMPLE) begin
              sample_cnt_nxt = '0;
              state_nxt      = ST_FINAL;
            end else begin
              sample_cnt_nxt = sample_cnt + 1'b1;
              state_nxt      = ST_WAIT;
            end
          end else begin
            bin_nxt = bin + 1'b1;
          end
        end
        ST_FINAL: begin
          if (res_ready) begin
            if (bin == LAST_BIN) begin
              state_nxt = ST_CLEAR;
              bin_nxt   = '0;
              frame_end = 1'b1;
            end else begin
              bin_nxt = bin + 1'b1;
            end
          end
        end
        default: begin
          state_nxt = ST_CLEAR;
          bin_nxt   = '0;
        end
      endcase
    end
  end

  always_comb begin
    dp_valid     = 1'b0;
    dp_op        = OP_CLEAR;
    sample_ready = 1'b0;
    if (live) begin
      case (state)
        ST_CLEAR: dp_valid = 1'b1;
        ST_WAIT:  sample_ready = en;
        ST_ITER: begin
          dp_valid = 1'b1;
          dp_op    = OP_ITER;
        end
        ST_FINAL: begin
          dp_valid = res_ready;
          dp_op    = OP_FINAL;
        end
        default: dp_valid = 1'b0;
      endcase
    end
  end

  assign dp_bin = bin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_sample  <= '0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      frame_done <= frame_end;
      if (frame_end) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
      if (accept) begin
        dp_sample <= sample_in;
      end
    end
  end

`ifdef GOERTZEL_SCHED_OVERRUN_EN
  logic drop;
  assign drop = sample_valid && !(live && (state == ST_WAIT) && en);

  goertzel_ovr_mon u_ovr_mon (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (soft_clr),
    .drop     (drop),
    .overrun  (overrun),
    .drop_cnt (drop_cnt)
  );
`else
  assign overrun  = 1'b0;
  assign drop_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: doc/goertzel_sched.md
GOERTZEL_SCHED -- requirements
Module: goertzel_sched

Interface
REQ-001 SHALL have parameter NUM_FREQS, default 10: number of frequency bins sharing one Goertzel datapath.
REQ-002 SHALL have parameter FRAME_LEN, default 256: samples per analysis frame, minimum 2.
REQ-003 SHALL have parameter DATA_WIDTH, default 16: sample width, signed.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port en, input, 1: when low, no new sample is accepted; an in-flight pass completes.
REQ-007 SHALL have port soft_clr, input, 1: synchronous frame abort and bin clear.
REQ-008 SHALL have port sample_in, input, DATA_WIDTH: signed sample, qualified by sample_valid.
REQ-009 SHALL have port sample_valid, input, 1: one-cycle strobe; there is no backpressure.
REQ-010 SHALL have port sample_ready, output, 1: high in WAIT while en is high.
REQ-011 SHALL have port dp_valid, output, 1: datapath op strobe.
REQ-012 SHALL have port dp_op, output, 2: op code CLEAR=0, ITER=1, FINAL=2.
REQ-013 SHALL have port dp_bin, output, clog2(NUM_FREQS): bin index, which also indexes the coefficient ROM.
REQ-014 SHALL have port dp_sample, output, DATA_WIDTH: latched sample, stable through an ITER pass.
REQ-015 SHALL have port res_ready, input, 1: downstream can take one magnitude.
REQ-016 SHALL have port frame_done, output, 1: one-cycle pulse after the last FINAL op.
REQ-017 SHALL have port frame_cnt, output, 16: completed frames, wrapping.
REQ-018 SHALL have port overrun, output, 1: sticky flag for a dropped sample.
REQ-019 SHALL have port drop_cnt, output, 8: saturating count of dropped samples.

Function
REQ-020 SHALL implement the states CLEAR, WAIT, ITER and FINAL, with one bin counter.
REQ-021 In CLEAR, SHALL issue dp_op=CLEAR for bins 0..NUM_FREQS-1, one per cycle, then go to WAIT.
REQ-022 In WAIT with en high and sample_valid high, SHALL latch sample_in to dp_sample and go to ITER with bin 0.
REQ-023 In ITER, SHALL issue dp_op=ITER with bins 0..NUM_FREQS-1 in consecutive cycles.
REQ-024 Latency: a sample accepted at cycle t SHALL produce bin 0 at t+1 and bin NUM_FREQS-1 at t+NUM_FREQS.
REQ-025 After the last ITER bin, SHALL increment sample_cnt; if it reaches FRAME_LEN, SHALL zero it and go to FINAL, otherwise go to WAIT.
REQ-026 In FINAL, SHALL issue dp_op=FINAL for the current bin only in cycles where res_ready is high, advancing the bin on each issue.
REQ-027 While res_ready is low, SHALL hold the bin.
REQ-028 After the last FINAL bin is issued, SHALL pulse frame_done, increment frame_cnt and go to CLEAR.
REQ-029 SHALL treat sample_valid high outside a WAIT-with-en-high cycle as a dropped sample; a dropped sample never alters dp_sample.
REQ-030 SHALL give soft_clr priority over all other events: next state CLEAR at bin 0, sample_cnt zeroed, no frame_done and frame_cnt unchanged.
REQ-031 SHALL hold dp_valid low in any cycle in which no op is issued, and dp_op/dp_bin SHALL be don't-care in those cycles.
REQ-032 SHALL keep frame_cnt wrapping from 16'hFFFF to 0.

Reset
REQ-033 On rst_n low, SHALL set state to CLEAR at bin 0 and sample_cnt to 0.
REQ-034 On rst_n low, SHALL drive all outputs to 0; the post-reset CLEAR sweep then starts on the first clock.
REQ-035 Reset mid-frame SHALL discard all progress without emitting frame_done.

Configuration
REQ-036 With macro GOERTZEL_SCHED_OVERRUN_EN defined, overrun SHALL set on a dropped sample and stay set until reset or soft_clr.
REQ-037 With the macro defined, drop_cnt SHALL count dropped samples and saturate at 255.
REQ-038 Without the macro, overrun and drop_cnt SHALL be tied to 0 and no monitor logic SHALL exist.

Structure
REQ-039 Package goertzel_pkg SHALL hold the op-code constants, the state encoding and the FRAME_CNT_W=16 constant.
REQ-040 The overrun logic SHALL be sub-module goertzel_ovr_mon, instantiated only under GOERTZEL_SCHED_OVERRUN_EN.

Verification (NUM_FREQS=4, FRAME_LEN=4)
REQ-041 Reset release: dp_valid high 4 cycles with CLEAR bins 0,1,2,3, then sample_ready=1.
REQ-042 sample_in=16'h1234 at t: ITER bins 0..3 at t+1..t+4 with dp_sample=16'h1234 held.
REQ-043 4 samples with res_ready=1: 4 FINAL ops, frame_done 1 cycle after, frame_cnt=1.
REQ-044 During FINAL, res_ready low 3 cycles at bin 2: dp_valid low and bin held at 2.
REQ-045 sample_valid at t+2 of an ITER pass (macro on): sample dropped, overrun=1, drop_cnt=1; sample_cnt unchanged.
REQ-046 soft_clr at sample 3 together with sample_valid: CLEAR sweep, no frame_done, frame_cnt unchanged.
